// File: rtl/mdu_client_pkg.sv
// Shared types for the MDU client: opcodes, request ops and FSM states.
// Opcode values match the MDU's decode.
package mdu_client_pkg;

  typedef logic [31:0] word_t;
  typedef logic [3:0]  mop_t;

  localparam mop_t MOP_NOP   = 4'd0;
  localparam mop_t MOP_MULT  = 4'd1;
  localparam mop_t MOP_MULTU = 4'd2;
  localparam mop_t MOP_DIV   = 4'd3;
  localparam mop_t MOP_DIVU  = 4'd4;
  localparam mop_t MOP_MFHI  = 4'd5;
  localparam mop_t MOP_MFLO  = 4'd6;
  localparam mop_t MOP_MTHI  = 4'd7;
  localparam mop_t MOP_MTLO  = 4'd8;

  localparam int unsigned WD_W = 5;

  typedef enum logic [1:0] {
    REQ_MULT  = 2'b00,
    REQ_MULTU = 2'b01,
    REQ_DIV   = 2'b10,
    REQ_DIVU  = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_RD_HI = 3'd4,
    S_RD_LO = 3'd5,
    S_RESP  = 3'd6
  } state_e;

  function automatic mop_t map_op(input logic [1:0] op);
    mop_t m;
    unique case (op)
      REQ_MULT:  m = MOP_MULT;
      REQ_MULTU: m = MOP_MULTU;
      REQ_DIV:   m = MOP_DIV;
      REQ_DIVU:  m = MOP_DIVU;
    endcase
    return m;
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_client_if.sv
// Request/response bus between a requester and the MDU client.
// master drives requests and consumes responses; slave is the client.
interface mdu_client_if;
  import mdu_client_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  word_t       req_a;
  word_t       req_b;
  logic        resp_valid;
  logic        resp_ready;
  word_t       resp_hi;
  word_t       resp_lo;
  logic        resp_err;
  logic        resp_dz;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_hi,
    input  resp_lo,
    input  resp_err,
    input  resp_dz
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_hi,
    output resp_lo,
    output resp_err,
    output resp_dz
  );

endinterface

// File: rtl/mdu_client.sv
// Sequences one MULT/DIV through the MDU: issue, wait on busy, read HI/LO.
// A watchdog bounds the wait; protocol faults are reported as resp_err.
module mdu_client
  import mdu_client_pkg::*;
#(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        reset_n,
  mdu_client_if.slave bus,
  output logic        mdu_start,
  output mop_t        mdu_op,
  output word_t       mdu_d1,
  output word_t       mdu_d2,
  input  logic        mdu_busy,
  input  word_t       mdu_hi_rd,
  input  word_t       mdu_lo_rd
);

  localparam logic [WD_W-1:0] WD_LAST =
    WD_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  mop_t            op_q, op_d;
  word_t           a_q, a_d;
  word_t           b_q, b_d;
  word_t           hi_q, hi_d;
  word_t           lo_q, lo_d;
  logic            err_q, err_d;
  logic            dz_q, dz_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            ready;
  logic            accept;

  // Ready is masked by reset so nothing is accepted while held.
  assign ready  = reset_n && (state_q == S_IDLE);
  assign accept = bus.req_valid && ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= MOP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
      dz_q    <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      dz_q    <= dz_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    err_d     = err_q;
    dz_d      = dz_q;
    wd_d      = wd_q;
    mdu_start = 1'b0;
    mdu_op    = MOP_NOP;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d    = map_op(bus.req_op);
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          dz_d    = is_div(bus.req_op)
                    && (bus.req_b == '0);
          err_d   = 1'b0;
          hi_d    = '0;
          lo_d    = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mdu_start = 1'b1;
        mdu_op    = op_q;
        state_d   = S_ARM;
      end
      S_ARM: begin
        if (mdu_busy) begin
          wd_d    = '0;
          state_d = S_WAIT;
        end else begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_WAIT: begin
        wd_d = (wd_q == '1) ? wd_q
                            : wd_q + 1'b1;
        // wd_q counts WAIT cycles already spent
        if (!mdu_busy) begin
          state_d = S_RD_HI;
        end else if (wd_q >= WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RD_HI: begin
        mdu_op  = MOP_MFHI;
        hi_d    = mdu_hi_rd;
        state_d = S_RD_LO;
      end
      S_RD_LO: begin
        mdu_op  = MOP_MFLO;
        lo_d    = mdu_lo_rd;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mdu_d1         = a_q;
  assign mdu_d2         = b_q;

  assign bus.req_ready  = ready;
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_hi    = hi_q;
  assign bus.resp_lo    = lo_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_dz    = dz_q;

endmodule

// File: tb/tb_mdu_client.sv
// Directed bench for mdu_client with a behavioural MDU stand-in.
// MDU busy lasts 5 cycles for multiplies and 10 for divides.
module tb_mdu_client;
  import mdu_client_pkg::*;

  logic  clk = 1'b0;
  logic  reset_n = 1'b0;
  logic  mdu_start;
  mop_t  mdu_op;
  word_t mdu_d1, mdu_d2;
  logic  mdu_busy;
  word_t mdu_hi_rd, mdu_lo_rd;

  mdu_client_if bus();

  mdu_client #(.TIMEOUT(31)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .mdu_start (mdu_start),
    .mdu_op    (mdu_op),
    .mdu_d1    (mdu_d1),
    .mdu_d2    (mdu_d2),
    .mdu_busy  (mdu_busy),
    .mdu_hi_rd (mdu_hi_rd),
    .mdu_lo_rd (mdu_lo_rd)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_start = 0;
  int   start_cyc = 0;
  mop_t start_op = MOP_NOP;
  int   n_mf = 0;
  int   n_mt = 0;
  int   mode = 0;
  int   acc = 0;

  logic [4:0] m_cnt = '0;
  word_t      m_hi = '0;
  word_t      m_lo = '0;

  function automatic logic [63:0] mdu_calc(
    input mop_t op, input word_t a, input word_t b);
    logic signed [63:0] sa, sb;
    logic signed [31:0] qa, qb;
    logic [63:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    qa = a;
    qb = b;
    r  = '0;
    case (op)
      MOP_MULT:  r = sa * sb;
      MOP_MULTU: r = {32'd0, a} * {32'd0, b};
      MOP_DIV:   if (b != 0) r = {32'(qa % qb), 32'(qa / qb)};
      MOP_DIVU:  if (b != 0) r = {a % b, a / b};
      default:   r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (mdu_start) begin
      m_cnt <= (mdu_op == MOP_MULT || mdu_op == MOP_MULTU)
               ? 5'd5 : 5'd10;
      {m_hi, m_lo} <= mdu_calc(mdu_op, mdu_d1, mdu_d2);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 5'd1;
    end
  end

  assign mdu_busy  = (mode == 1) ? 1'b0 :
                     (mode == 2) ? 1'b1 : (m_cnt != 0);
  assign mdu_hi_rd = (mdu_op == MOP_MFHI) ? m_hi : 32'hDEAD_BEEF;
  assign mdu_lo_rd = (mdu_op == MOP_MFLO) ? m_lo : 32'hDEAD_BEEF;

  always @(negedge clk) begin
    if (mdu_start) begin
      n_start++;
      start_cyc = cyc;
      start_op  = mdu_op;
    end
    if (mdu_op == MOP_MFHI || mdu_op == MOP_MFLO) n_mf++;
    if (mdu_op == MOP_MTHI || mdu_op == MOP_MTLO) n_mt++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op,
                       input word_t a, input word_t b);
    int n;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      step();
      n++;
    end
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    acc = cyc;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    int n;
    n   = 0;
    lat = -1;
    while (n < 60) begin
      if (bus.resp_valid) begin
        lat = cyc - acc;
        break;
      end
      step();
      n++;
    end
  endtask

  task automatic take_resp();
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    int    lat;
    int    st0, mf0;
    logic  bad;
    word_t h0, l0;

    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;

    repeat (3) step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_start_op", {mdu_start, mdu_op}, 0);
    chk("rst_d1_d2", {mdu_d1, mdu_d2}, 0);
    chk("rst_hi_lo", {bus.resp_hi, bus.resp_lo}, 0);
    chk("rst_err_dz", {bus.resp_err, bus.resp_dz}, 0);
    reset_n = 1'b1;
    #1;
    chk("idle_ready", bus.req_ready, 1);
    step();

    // MULT -2 * 3 = -6
    st0 = n_start;
    issue(2'b00, 32'hFFFF_FFFE, 32'd3);
    chk("mult_ready_low", bus.req_ready, 0);
    wait_resp(lat);
    chk("mult_lat", lat, 10);
    chk("mult_hi", bus.resp_hi, 64'hFFFF_FFFF);
    chk("mult_lo", bus.resp_lo, 64'hFFFF_FFFA);
    chk("mult_nstart", n_start - st0, 1);
    chk("mult_start_cyc", start_cyc - acc, 1);
    chk("mult_start_op", start_op, MOP_MULT);
    chk("mult_err_dz", {bus.resp_err, bus.resp_dz}, 0);
    take_resp();
    chk("mult_done", {bus.resp_valid, bus.req_ready}, 2'b01);

    // DIVU 100 / 7 = 14 r 2
    issue(2'b11, 32'd100, 32'd7);
    wait_resp(lat);
    chk("divu_lat", lat, 15);
    chk("divu_start_op", start_op, MOP_DIVU);
    chk("divu_lo", bus.resp_lo, 14);
    chk("divu_hi", bus.resp_hi, 2);
    chk("divu_err_dz", {bus.resp_err, bus.resp_dz}, 0);
    take_resp();

    // DIV 5 / 0: flagged but still issued
    st0 = n_start;
    issue(2'b10, 32'd5, 32'd0);
    wait_resp(lat);
    chk("dz_lat", lat, 15);
    chk("dz_nstart", n_start - st0, 1);
    chk("dz_dz_err", {bus.resp_dz, bus.resp_err}, 2'b10);
    chk("dz_hi_lo", {bus.resp_hi, bus.resp_lo}, 0);
    take_resp();

    // busy never rises
    mode = 1;
    issue(2'b00, 32'd4, 32'd5);
    wait_resp(lat);
    chk("stuck0_lat", lat, 3);
    chk("stuck0_err", bus.resp_err, 1);
    chk("stuck0_hi_lo", {bus.resp_hi, bus.resp_lo}, 0);
    take_resp();

    // busy never falls: watchdog abort
    mode = 2;
    mf0 = n_mf;
    issue(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) step();
    chk("wait_d1_d2", {mdu_d1, mdu_d2}, 64'h1234_5678_9ABC_DEF0);
    chk("wait_op_nop", mdu_op, MOP_NOP);
    wait_resp(lat);
    chk("stuck1_lat", lat, 34);
    chk("stuck1_err", bus.resp_err, 1);
    chk("stuck1_no_mf", n_mf - mf0, 0);
    chk("stuck1_hi_lo", {bus.resp_hi, bus.resp_lo}, 0);
    take_resp();
    mode = 0;
    repeat (12) step();

    // back-pressure on response
    issue(2'b01, 32'hFFFF_FFFF, 32'd2);
    wait_resp(lat);
    chk("multu_lat", lat, 10);
    chk("multu_hi", bus.resp_hi, 1);
    chk("multu_lo", bus.resp_lo, 64'hFFFF_FFFE);
    h0  = bus.resp_hi;
    l0  = bus.resp_lo;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!bus.resp_valid || bus.req_ready ||
          bus.resp_hi != h0 || bus.resp_lo != l0 ||
          bus.resp_err || bus.resp_dz)
        bad = 1'b1;
    end
    chk("hold_stable", bad, 0);
    take_resp();

    // reset in the middle of WAIT
    issue(2'b11, 32'd1000, 32'd10);
    repeat (4) step();
    chk("pre_rst_in_wait", {bus.req_ready, mdu_op}, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_ready", bus.req_ready, 0);
    chk("arst_valid_start", {bus.resp_valid, mdu_start}, 0);
    chk("arst_op", mdu_op, MOP_NOP);
    chk("arst_d1_d2", {mdu_d1, mdu_d2}, 0);
    chk("arst_err_dz", {bus.resp_err, bus.resp_dz}, 0);
    chk("arst_hi_lo", {bus.resp_hi, bus.resp_lo}, 0);
    step();
    step();
    reset_n = 1'b1;
    #1;
    chk("arst_idle_ready", bus.req_ready, 1);
    repeat (15) step();

    // MULT 7 * -3 = -21 after reset
    issue(2'b00, 32'd7, 32'hFFFF_FFFD);
    wait_resp(lat);
    chk("post_lat", lat, 10);
    chk("post_hi", bus.resp_hi, 64'hFFFF_FFFF);
    chk("post_lo", bus.resp_lo, 64'hFFFF_FFEB);
    chk("post_err_dz", {bus.resp_err, bus.resp_dz}, 0);
    take_resp();

    chk("never_mthi_mtlo", n_mt, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
